// File: rtl/input_status_scan_pkg.sv
// Shared types and helpers for the input_status_scan block: FSM state, channel-index
// width and status-word parity.
package input_status_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Widest status word the parity helper accepts.
   localparam int PAR_MAX_W = 64;

   function automatic int calc_chw(input int ch);
      return (ch <= 2) ? 1 : $clog2(ch);
   endfunction

   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/input_status_scan_channel.sv
// One status channel: serial live register, held snapshot, masked merge and
// change detection with sticky pending/overrun flags.
module isc_channel
   import input_status_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             ival,
   input  logic             shift_en,
   input  logic             hold,
   input  logic [WIDTH-1:0] sel_mask,
   input  logic             grant_clr,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] merged,
   output logic             pending,
   output logic             overrun
);

   logic [WIDTH-1:0] live;
   logic [WIDTH-1:0] held;
   logic [WIDTH-1:0] prev;
   logic             change;

   assign merged = (sel_mask & live) | (~sel_mask & held);
   assign change = (merged != prev);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         live    <= '0;
         held    <= '0;
         prev    <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (shift_en) live <= {live[WIDTH-2:0], ival};
         // held samples live before this edge's shift lands
         if (hold)     held <= live;
         prev <= merged;
         // a fresh change outranks the arbiter's clear, so the newer word is reported later
         if (change)         pending <= 1'b1;
         else if (grant_clr) pending <= 1'b0;
         if (change && pending) overrun <= 1'b1;
         else if (ovr_clr)      overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/input_status_scan.sv
// Multi-channel input-status scanner with round-robin change reporting.
// Define INPUT_STATUS_PARITY_EN to append an even-parity bit to out_status.
module input_status_scan
   import input_status_pkg::*;
#(
   parameter  int WIDTH = 9,
   parameter  int CH    = 4,
   localparam int CHW   = calc_chw(CH),
`ifdef INPUT_STATUS_PARITY_EN
   localparam int OW    = WIDTH + 1
`else
   localparam int OW    = WIDTH
`endif
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic [CH-1:0]    ival,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] sel_mask,
   input  logic             hold,
   input  logic             ovr_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHW-1:0]   out_ch,
   output logic [OW-1:0]    out_status,
   output logic [CH-1:0]    overrun,
   output state_t           state_dbg
);

   // Report port: a report transfers on an edge where out_valid & out_ready; while
   // out_valid is high out_ch/out_status stay stable; out_ready is ignored otherwise.

   logic [WIDTH-1:0] merged [CH];
   logic [CH-1:0]    pending;
   logic [CH-1:0]    grant_clr;
   logic [CHW-1:0]   ptr;
   logic [CHW-1:0]   gnt_ch;
   logic [CHW-1:0]   next_ptr;
   logic [OW-1:0]    status_word;
   logic             gnt_any;
   logic             load;
   logic             ack;
   state_t           state;
   state_t           state_nx;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      isc_channel #(.WIDTH(WIDTH)) u_ch (
         .sysclk    (sysclk),
         .reset     (reset),
         .ival      (ival[c]),
         .shift_en  (shift_en),
         .hold      (hold),
         .sel_mask  (sel_mask),
         .grant_clr (grant_clr[c]),
         .ovr_clr   (ovr_clr),
         .merged    (merged[c]),
         .pending   (pending[c]),
         .overrun   (overrun[c])
      );
   end

   // Scan downward so the last hit is the first pending channel at or after ptr.
   always_comb begin : arb
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_ch  = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % CH;
         if (pending[idx]) begin
            gnt_any = 1'b1;
            gnt_ch  = CHW'(idx);
         end
      end
   end

`ifdef INPUT_STATUS_PARITY_EN
   assign status_word = {even_parity(PAR_MAX_W'(merged[gnt_ch])), merged[gnt_ch]};
`else
   assign status_word = merged[gnt_ch];
`endif

   assign next_ptr  = CHW'((int'(out_ch) + 1) % CH);
   assign state_dbg = state;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (gnt_any) state_nx = PRESENT;
         PRESENT: if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      ack       = 1'b0;
      grant_clr = '0;
      case (state)
         IDLE:    load = gnt_any;
         PRESENT: ack  = out_valid & out_ready;
         default: ;
      endcase
      for (int c = 0; c < CH; c++) grant_clr[c] = load && (gnt_ch == CHW'(c));
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_status <= '0;
         ptr        <= '0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_ch     <= gnt_ch;
         out_status <= status_word;
      end else if (ack) begin
         out_valid  <= 1'b0;
         ptr        <= next_ptr;
      end
   end

endmodule

// File: tb/tb_input_status_scan.sv
// Directed self-checking bench for input_status_scan (WIDTH=9, CH=4).
module tb_input_status_scan;
   import input_status_pkg::*;

   localparam int WIDTH = 9;
   localparam int CH    = 4;
   localparam int CHW   = 2;
`ifdef INPUT_STATUS_PARITY_EN
   localparam int OW    = WIDTH + 1;
`else
   localparam int OW    = WIDTH;
`endif

   logic             sysclk = 1'b0;
   logic             reset = 1'b0;
   logic [CH-1:0]    ival = '0;
   logic             shift_en = 1'b0;
   logic [WIDTH-1:0] sel_mask = '0;
   logic             hold = 1'b0;
   logic             ovr_clr = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CHW-1:0]   out_ch;
   logic [OW-1:0]    out_status;
   logic [CH-1:0]    overrun;
   state_t           state_dbg;

   int checks = 0;
   int errors = 0;

   input_status_scan #(.WIDTH(WIDTH), .CH(CH)) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .ival       (ival),
      .shift_en   (shift_en),
      .sel_mask   (sel_mask),
      .hold       (hold),
      .ovr_clr    (ovr_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_status (out_status),
      .overrun    (overrun),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   always #5 sysclk = ~sysclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // drivers
   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      ival      = '0;
      shift_en  = 1'b0;
      hold      = 1'b0;
      ovr_clr   = 1'b0;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic shift_once(input logic [CH-1:0] v);
      ival     = v;
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic ack();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [OW-1:0] exp_word(input logic [WIDTH-1:0] v);
`ifdef INPUT_STATUS_PARITY_EN
      return {^v, v};
`else
      return v;
`endif
   endfunction

   // scenarios
   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_ch !== '0) begin
         errors++; $display("FAIL reset_ch: got %h expected 0", out_ch);
      end
      checks++;
      if (out_status !== '0) begin
         errors++; $display("FAIL reset_status: got %h expected 0", out_status);
      end
      checks++;
      if (overrun !== '0) begin
         errors++; $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      checks++;
      if (state_dbg !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg);
      end
   endtask

   task automatic test_shift_ch0();
      logic [WIDTH-1:0] exp;
      bit ok;
      do_reset();
      sel_mask = 9'h1FF;
      exp = '0;
      for (int k = 0; k < 9; k++) begin
         shift_once(4'b0001);
         exp = {exp[WIDTH-2:0], 1'b1};
         wait_valid(ok);
         checks++;
         if (!ok || out_ch !== 2'd0 || out_status !== exp_word(exp)) begin
            errors++;
            $display("FAIL shift_ch0[%0d]: got valid=%b ch=%0d status=%h expected ch=0 status=%h",
                     k, ok, out_ch, out_status, exp_word(exp));
         end
         ack();
      end
      // three changes without a consumer: the grant captures the second value
      ival     = '0;
      shift_en = 1'b1;
      repeat (3) tick();
      shift_en = 1'b0;
      tick();
      checks++;
      if (overrun[0] !== 1'b1) begin
         errors++; $display("FAIL shift_overrun: got %b expected 1", overrun[0]);
      end
      checks++;
      if (out_valid !== 1'b1 || out_status !== exp_word(9'h1FC)) begin
         errors++;
         $display("FAIL shift_stall_status: got valid=%b status=%h expected valid=1 status=%h",
                  out_valid, out_status, exp_word(9'h1FC));
      end
   endtask

   task automatic test_hold_merge();
      logic [WIDTH-1:0] v;
      bit ok;
      bit seen;
      do_reset();
      sel_mask = '0;
      v = 9'h0A5;
      shift_en = 1'b1;
      for (int b = WIDTH - 1; b >= 0; b--) begin
         ival = {1'b0, v[b], 2'b00};
         tick();
      end
      shift_en = 1'b0;
      hold = 1'b1;
      tick();
      hold = 1'b0;
      // with an all-held mask the snapshot itself is a change
      wait_valid(ok);
      checks++;
      if (!ok || out_ch !== 2'd2 || out_status !== exp_word(9'h0A5)) begin
         errors++;
         $display("FAIL hold_snapshot: got valid=%b ch=%0d status=%h expected ch=2 status=%h",
                  ok, out_ch, out_status, exp_word(9'h0A5));
      end
      ack();
      v = 9'h15A;
      shift_en = 1'b1;
      for (int b = WIDTH - 1; b >= 0; b--) begin
         ival = {1'b0, v[b], 2'b00};
         tick();
      end
      shift_en = 1'b0;
      ival = '0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL hold_masked_quiet: got valid=%b expected 0", out_valid);
      end
      sel_mask = 9'h00F;
      wait_valid(ok);
      checks++;
      if (!ok || out_ch !== 2'd2 || out_status !== exp_word(9'h0AA)) begin
         errors++;
         $display("FAIL hold_merge: got valid=%b ch=%0d status=%h expected ch=2 status=%h",
                  ok, out_ch, out_status, exp_word(9'h0AA));
      end
      ack();
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL hold_static: got a repeat report expected none");
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int   exp_c [8] = '{0, 0, 0, 1, 0, 3, 0, 0};
      bit ok;
      do_reset();
      sel_mask = 9'h1FF;
      shift_once(4'b1011);
      ival = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== exp_v[i] || (exp_v[i] && out_ch !== CHW'(exp_c[i]))) begin
            errors++;
            $display("FAIL rr_cycle[%0d]: got valid=%b ch=%0d expected valid=%b ch=%0d",
                     i, out_valid, out_ch, exp_v[i], exp_c[i]);
         end
      end
      out_ready = 1'b0;
      // move ptr to 2, then ch3 must win over ch1
      do_reset();
      sel_mask = 9'h1FF;
      shift_once(4'b0010);
      wait_valid(ok);
      checks++;
      if (!ok || out_ch !== 2'd1) begin
         errors++; $display("FAIL rr_prime: got valid=%b ch=%0d expected ch=1", ok, out_ch);
      end
      ack();
      shift_once(4'b1010);
      ival = '0;
      wait_valid(ok);
      checks++;
      if (!ok || out_ch !== 2'd3 || out_status !== exp_word(9'h001)) begin
         errors++;
         $display("FAIL rr_wrap_first: got valid=%b ch=%0d status=%h expected ch=3 status=%h",
                  ok, out_ch, out_status, exp_word(9'h001));
      end
      ack();
      wait_valid(ok);
      checks++;
      if (!ok || out_ch !== 2'd1 || out_status !== exp_word(9'h003)) begin
         errors++;
         $display("FAIL rr_wrap_second: got valid=%b ch=%0d status=%h expected ch=1 status=%h",
                  ok, out_ch, out_status, exp_word(9'h003));
      end
      ack();
   endtask

   task automatic test_overrun();
      do_reset();
      sel_mask = 9'h1FF;
      shift_once(4'b0010);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_status !== exp_word(9'h001)) begin
         errors++;
         $display("FAIL ovr_first: got valid=%b ch=%0d status=%h expected valid=1 ch=1 status=%h",
                  out_valid, out_ch, out_status, exp_word(9'h001));
      end
      shift_once(4'b0010);
      tick();
      shift_once(4'b0010);
      tick();
      checks++;
      if (overrun !== 4'b0010) begin
         errors++; $display("FAIL ovr_set: got %b expected 0010", overrun);
      end
      checks++;
      if (out_status !== exp_word(9'h001)) begin
         errors++;
         $display("FAIL ovr_held_status: got %h expected %h", out_status, exp_word(9'h001));
      end
      shift_once(4'b0010);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 4'b0010) begin
         errors++; $display("FAIL ovr_set_wins: got %b expected 0010", overrun);
      end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 4'b0000) begin
         errors++; $display("FAIL ovr_clear: got %b expected 0000", overrun);
      end
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
         errors++;
         $display("FAIL ovr_still_presented: got valid=%b ch=%0d expected valid=1 ch=1",
                  out_valid, out_ch);
      end
   endtask

   task automatic test_reset_midflight();
      bit seen;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_pre: got valid=%b expected 1", out_valid);
      end
      out_ready = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL mid_async_drop: got valid=%b state=%0d expected valid=0 IDLE",
                  out_valid, state_dbg);
      end
      out_ready = 1'b0;
      ival = '0;
      #3;
      reset = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ch !== '0 || out_status !== '0 || overrun !== '0) begin
         errors++;
         $display("FAIL mid_post: got valid=%b ch=%0d status=%h overrun=%b expected all 0",
                  out_valid, out_ch, out_status, overrun);
      end
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL mid_discarded: got a report expected none");
      end
   endtask

`ifdef INPUT_STATUS_PARITY_EN
   task automatic test_parity();
      logic [OW-1:0] exp_tab [3] = '{10'h201, 10'h003, 10'h207};
      bit ok;
      do_reset();
      sel_mask = 9'h1FF;
      for (int k = 0; k < 3; k++) begin
         shift_once(4'b0001);
         wait_valid(ok);
         checks++;
         if (!ok || out_status !== exp_tab[k]) begin
            errors++;
            $display("FAIL parity[%0d]: got valid=%b status=%h expected %h",
                     k, ok, out_status, exp_tab[k]);
         end
         ack();
      end
   endtask
`endif

   initial begin
      #12;
      reset = 1'b1;
      tick();
      test_reset();
      test_shift_ch0();
      test_hold_merge();
      test_back_to_back();
      test_overrun();
      test_reset_midflight();
`ifdef INPUT_STATUS_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_status_scan.md
# input_status_scan

Parametrised, multi-channel input-status block. Each channel shifts a serial input into a live register, merges it bit-by-bit with a held snapshot under a shared select mask, and detects changes in the merged status word. Changed channels are reported one at a time, in round-robin order, over a valid/ready output port. The block sits between raw serial status inputs and the status/interrupt aggregation logic.

## Interface
- WIDTH, 9, status word width per channel (min 2)
- CH, 4, channel count (1..16); CHW = max(1, clog2(CH)) is a derived localparam
- sysclk  in  1  clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-low reset
- ival  in  CH  serial input bit, one per channel
- shift_en  in  1  shift every live register by one bit this cycle
- sel_mask  in  WIDTH  per bit: 1 selects the live bit, 0 selects the held bit
- hold  in  1  copy every live register into its held register
- ovr_clr  in  1  clear all overrun flags
- out_valid  out  1  report present
- out_ready  in  1  consumer accepts the report
- out_ch  out  CHW  channel index of the report
- out_status  out  WIDTH (+1 with parity)  merged status word of the reported channel
- overrun  out  CH  sticky flag per channel: a change was lost

## Operation
- Reset (reset=0) clears every register to 0: live, held, prev, pending, overrun, out_valid, out_ch, out_status and ptr. The FSM returns to IDLE.
- Live register: when shift_en=1, live[c] <= {live[c][WIDTH-2:0], ival[c]}.
- Held register: when hold=1, held[c] <= live[c], using the live value before any same-edge shift.
- Merge (combinational): merged[c] = (sel_mask & live[c]) | (~sel_mask & held[c]).
- Change detect: prev[c] <= merged[c] on every edge. change[c] = (merged[c] != prev[c]).
- On change[c], pending[c] <= 1. If pending[c] is already 1, overrun[c] <= 1 as well.
- ovr_clr clears overrun. If ovr_clr and an overrun set occur on the same edge, the set wins.
- FSM, state IDLE:
  - If any pending bit is set, grant the first pending channel at or after ptr, searching upward with wrap-around.
  - On the grant: out_ch <= c, out_status <= merged[c], pending[c] <= 0, out_valid <= 1, go to PRESENT.
- FSM, state PRESENT:
  - out_valid, out_ch and out_status are held stable.
  - When out_valid & out_ready: out_valid <= 0, ptr <= (c+1) mod CH, go to IDLE.
- A clear of pending[c] by the grant and a new change[c] on the same edge: the set wins, so the newer value is reported later.
- The reported word is the latest merged value at grant time. Intermediate values are lost and flagged by overrun.

## Timing
- Latency: merged changes after edge k → pending set at edge k+1 → out_valid high after edge k+2.
- Back-to-back reports: a handshake at edge j is followed by IDLE, and the next out_valid rises after edge j+1. This is one bubble cycle.
- out_ready is ignored while out_valid=0.
- reset asserted mid-handshake drops out_valid asynchronously; the in-flight report is discarded.
- CH=1: ptr stays 0 and out_ch is 1 bit, tied to 0.

## Configuration
- INPUT_STATUS_PARITY_EN defined:
  - out_status is WIDTH+1 bits.
  - Bit WIDTH is the even parity (XOR reduction) of merged[c], computed at grant time.
- INPUT_STATUS_PARITY_EN undefined: out_status is WIDTH bits and no parity logic is present.

## Structure
- Package input_status_pkg contains:
  - the FSM state typedef {IDLE, PRESENT};
  - the CHW width function;
  - the parity function.
- Sub-module isc_channel holds live, held, prev, pending and overrun for one channel. It is instantiated CH times.
- The top level holds the round-robin arbiter, the FSM and the output registers.

## Test plan
- Reset, then shift_en=1 for 9 cycles with ival[0]=1, sel_mask=9'h1FF → reports on ch0 with out_status 9'h001, 9'h003, …, 9'h1FF. overrun[0] is set if out_ready is held 0.
- live[2]=9'h0A5 with hold, then live[2]=9'h15A and sel_mask=9'h00F → merged 9'h0AA. Report ch2 with out_status 9'h0AA; ch2 is not reported again while inputs are static.
- Changes on ch0, ch1 and ch3 on the same edge, out_ready=1 → reports in order ch0, ch1, ch3 with one bubble cycle between reports. Changes on ch3 and ch1 next → order ch3, ch1, because of the wrap from ptr.
- out_ready=0 while ch1 changes twice → overrun[1]=1 and out_status holds its first value. ovr_clr on the same edge as a new overrun → overrun stays 1.
- reset pulsed low while out_valid=1 → out_valid=0 immediately and all outputs are 0 after reset release.
- With INPUT_STATUS_PARITY_EN defined: report of 9'h007 → out_status 10'h207; report of 9'h003 → 10'h003.
